// File: rtl/compression_pio_master_if.sv
// Command/response stream and Avalon-MM PIO bus signals for compression_pio_master.
// The master modport is the bridge's view; slave is the sequencer/slave-side view.
interface compression_pio_master_if #(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_error;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic              read_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, readdata, waitrequest,
        output cmd_ready, rsp_valid, rsp_error, rsp_rdata,
               address, chipselect, write_n, read_n, writedata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, readdata, waitrequest,
        input  cmd_ready, rsp_valid, rsp_error, rsp_rdata,
               address, chipselect, write_n, read_n, writedata
    );
endinterface

// File: rtl/compression_pio_master.sv
// Avalon-MM master for PIO slaves: one command at a time, one bus transaction each,
// with waitrequest stalls, fixed read latency, optional timeout abort and a held response.
module compression_pio_master #(
    parameter int unsigned ADDR_W         = 2,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned READ_LATENCY   = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          reset_n,
    compression_pio_master_if.master      pio
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RDWAIT,
        S_RESP
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] RL_LAST = 16'(READ_LATENCY - 1);

    state_t            state;
    logic [15:0]       cnt;
    logic              wr_q;
    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic              rsp_error_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              cs_q;
    logic              write_n_q;
    logic              read_n_q;

    assign pio.cmd_ready  = cmd_ready_q;
    assign pio.rsp_valid  = rsp_valid_q;
    assign pio.rsp_error  = rsp_error_q;
    assign pio.rsp_rdata  = rsp_rdata_q;
    assign pio.address    = addr_q;
    assign pio.writedata  = wdata_q;
    assign pio.chipselect = cs_q;
    assign pio.write_n    = write_n_q;
    assign pio.read_n     = read_n_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            wr_q        <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cs_q        <= 1'b0;
            write_n_q   <= 1'b1;
            read_n_q    <= 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (pio.cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        wr_q        <= pio.cmd_write;
                        addr_q      <= pio.cmd_addr;
                        wdata_q     <= pio.cmd_wdata;
                        cs_q        <= 1'b1;
                        write_n_q   <= ~pio.cmd_write;
                        read_n_q    <= pio.cmd_write;
                        cnt         <= '0;
                        state       <= S_BUS;
                    end
                end

                S_BUS: begin
                    if (pio.waitrequest) begin
                        // cnt counts completed stalled cycles; abort on the TIMEOUT_CYCLES-th one
                        if (TIMEOUT_CYCLES != 0 && cnt == TO_LAST) begin
                            cs_q        <= 1'b0;
                            write_n_q   <= 1'b1;
                            read_n_q    <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= 1'b1;
                            rsp_rdata_q <= '0;
                            state       <= S_RESP;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end else begin
                        cs_q      <= 1'b0;
                        write_n_q <= 1'b1;
                        read_n_q  <= 1'b1;
                        if (wr_q) begin
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= 1'b0;
                            rsp_rdata_q <= '0;
                            state       <= S_RESP;
                        end else if (READ_LATENCY == 0) begin
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= 1'b0;
                            rsp_rdata_q <= pio.readdata;
                            state       <= S_RESP;
                        end else begin
                            cnt   <= '0;
                            state <= S_RDWAIT;
                        end
                    end
                end

                S_RDWAIT: begin
                    if (cnt == RL_LAST) begin
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= 1'b0;
                        rsp_rdata_q <= pio.readdata;
                        state       <= S_RESP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                S_RESP: begin
                    if (pio.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_compression_pio_master.sv
// Directed bench for compression_pio_master: dut0 has READ_LATENCY=0, dut1 READ_LATENCY=2,
// both TIMEOUT_CYCLES=8. dut0 talks to a small PIO register model at address 0.
module tb_compression_pio_master;
    localparam int unsigned AW = 2;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    int unsigned   tests = 0;
    int unsigned   errors = 0;
    logic [DW-1:0] out_port;
    logic [DW-1:0] rd1;

    always #5 clk = ~clk;

    compression_pio_master_if #(.ADDR_W(AW), .DATA_W(DW)) i0 ();
    compression_pio_master_if #(.ADDR_W(AW), .DATA_W(DW)) i1 ();

    compression_pio_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(0), .TIMEOUT_CYCLES(8)) dut0 (
        .clk(clk), .reset_n(reset_n), .pio(i0));
    compression_pio_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2), .TIMEOUT_CYCLES(8)) dut1 (
        .clk(clk), .reset_n(reset_n), .pio(i1));

    // PIO out_port register at address 0; other addresses read as zero
    always @(posedge clk)
        if (i0.chipselect && !i0.write_n && !i0.waitrequest && i0.address == '0)
            out_port <= i0.writedata;
    assign i0.readdata = (i0.address == '0) ? out_port : '0;
    assign i1.readdata = rd1;

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++; if (i0.chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b want 0", i0.chipselect); end
        tests++; if (i0.write_n !== 1'b1) begin errors++; $display("FAIL reset_write_n: got %b want 1", i0.write_n); end
        tests++; if (i0.read_n !== 1'b1) begin errors++; $display("FAIL reset_read_n: got %b want 1", i0.read_n); end
        tests++; if (i0.address !== 2'd0) begin errors++; $display("FAIL reset_address: got %h want 0", i0.address); end
        tests++; if (i0.writedata !== 32'd0) begin errors++; $display("FAIL reset_writedata: got %h want 0", i0.writedata); end
        tests++; if (i0.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", i0.rsp_valid); end
        tests++; if (i0.rsp_error !== 1'b0) begin errors++; $display("FAIL reset_rsp_error: got %b want 0", i0.rsp_error); end
        tests++; if (i0.rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", i0.rsp_rdata); end
        reset_n = 1'b1;
        @(negedge clk);
        tests++; if (i0.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", i0.cmd_ready); end
    endtask

    task automatic test_write();
        @(negedge clk);
        i0.cmd_valid = 1'b1; i0.cmd_write = 1'b1; i0.cmd_addr = 2'd0; i0.cmd_wdata = 32'h0000_00A5;
        @(negedge clk); // T+1
        i0.cmd_valid = 1'b0;
        tests++; if (i0.chipselect !== 1'b1) begin errors++; $display("FAIL wr_cs: got %b want 1", i0.chipselect); end
        tests++; if (i0.write_n !== 1'b0) begin errors++; $display("FAIL wr_write_n: got %b want 0", i0.write_n); end
        tests++; if (i0.read_n !== 1'b1) begin errors++; $display("FAIL wr_read_n: got %b want 1", i0.read_n); end
        tests++; if (i0.writedata !== 32'hA5) begin errors++; $display("FAIL wr_writedata: got %h want a5", i0.writedata); end
        tests++; if (i0.rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rsp_early: got %b want 0", i0.rsp_valid); end
        @(negedge clk); // T+2
        tests++; if (i0.chipselect !== 1'b0 || i0.write_n !== 1'b1) begin errors++; $display("FAIL wr_strobe_len: got cs=%b wn=%b want cs=0 wn=1", i0.chipselect, i0.write_n); end
        tests++; if (i0.rsp_valid !== 1'b1) begin errors++; $display("FAIL wr_rsp_valid: got %b want 1", i0.rsp_valid); end
        tests++; if (i0.rsp_error !== 1'b0) begin errors++; $display("FAIL wr_rsp_error: got %b want 0", i0.rsp_error); end
        tests++; if (i0.cmd_ready !== 1'b0) begin errors++; $display("FAIL wr_cmd_ready: got %b want 0", i0.cmd_ready); end
        tests++; if (out_port !== 32'hA5) begin errors++; $display("FAIL wr_out_port: got %h want a5", out_port); end
        i0.rsp_ready = 1'b1;
        @(negedge clk);
        i0.rsp_ready = 1'b0;
        tests++; if (i0.rsp_valid !== 1'b0 || i0.cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_handshake: got rv=%b cr=%b want rv=0 cr=1", i0.rsp_valid, i0.cmd_ready); end
    endtask

    task automatic test_read();
        logic [AW-1:0] addrs [2];
        logic [DW-1:0] exps [2];
        addrs[0] = 2'd1; exps[0] = 32'h0;
        addrs[1] = 2'd0; exps[1] = 32'h0000_00A5;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            i0.cmd_valid = 1'b1; i0.cmd_write = 1'b0; i0.cmd_addr = addrs[i]; i0.cmd_wdata = 32'hFFFF_FFFF;
            @(negedge clk);
            i0.cmd_valid = 1'b0;
            tests++; if (i0.chipselect !== 1'b1 || i0.read_n !== 1'b0 || i0.write_n !== 1'b1) begin errors++; $display("FAIL rd%0d_strobe: got cs=%b rn=%b wn=%b want 1 0 1", i, i0.chipselect, i0.read_n, i0.write_n); end
            tests++; if (i0.address !== addrs[i]) begin errors++; $display("FAIL rd%0d_address: got %h want %h", i, i0.address, addrs[i]); end
            @(negedge clk);
            tests++; if (i0.read_n !== 1'b1 || i0.chipselect !== 1'b0) begin errors++; $display("FAIL rd%0d_strobe_len: got cs=%b rn=%b want 0 1", i, i0.chipselect, i0.read_n); end
            tests++; if (i0.rsp_valid !== 1'b1) begin errors++; $display("FAIL rd%0d_rsp_valid: got %b want 1", i, i0.rsp_valid); end
            tests++; if (i0.rsp_rdata !== exps[i]) begin errors++; $display("FAIL rd%0d_rdata: got %h want %h", i, i0.rsp_rdata, exps[i]); end
            i0.rsp_ready = 1'b1;
            @(negedge clk);
            i0.rsp_ready = 1'b0;
        end
    endtask

    task automatic test_timeout();
        int unsigned strobes;
        strobes = 0;
        @(negedge clk);
        i0.waitrequest = 1'b1;
        i0.cmd_valid = 1'b1; i0.cmd_write = 1'b0; i0.cmd_addr = 2'd0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            i0.cmd_valid = 1'b0;
            if (i0.chipselect === 1'b1 && i0.read_n === 1'b0 && i0.rsp_valid === 1'b0) strobes++;
        end
        tests++; if (strobes != 8) begin errors++; $display("FAIL to_strobe_cycles: got %0d want 8", strobes); end
        @(negedge clk); // T+9
        tests++; if (i0.chipselect !== 1'b0 || i0.read_n !== 1'b1) begin errors++; $display("FAIL to_strobe_drop: got cs=%b rn=%b want 0 1", i0.chipselect, i0.read_n); end
        tests++; if (i0.rsp_valid !== 1'b1) begin errors++; $display("FAIL to_rsp_valid: got %b want 1", i0.rsp_valid); end
        tests++; if (i0.rsp_error !== 1'b1) begin errors++; $display("FAIL to_rsp_error: got %b want 1", i0.rsp_error); end
        tests++; if (i0.rsp_rdata !== 32'd0) begin errors++; $display("FAIL to_rsp_rdata: got %h want 0", i0.rsp_rdata); end
        i0.waitrequest = 1'b0;
        i0.rsp_ready = 1'b1;
        @(negedge clk);
        i0.rsp_ready = 1'b0;
    endtask

    task automatic test_wait_write();
        @(negedge clk);
        i0.waitrequest = 1'b1;
        i0.cmd_valid = 1'b1; i0.cmd_write = 1'b1; i0.cmd_addr = 2'd2; i0.cmd_wdata = 32'h1234_5678;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            i0.cmd_valid = 1'b0;
            tests++; if (i0.chipselect !== 1'b1 || i0.write_n !== 1'b0) begin errors++; $display("FAIL ww_strobe_c%0d: got cs=%b wn=%b want 1 0", k, i0.chipselect, i0.write_n); end
            tests++; if (i0.address !== 2'd2 || i0.writedata !== 32'h1234_5678) begin errors++; $display("FAIL ww_stable_c%0d: got a=%h d=%h want 2 12345678", k, i0.address, i0.writedata); end
            tests++; if (i0.rsp_valid !== 1'b0) begin errors++; $display("FAIL ww_rsp_early_c%0d: got %b want 0", k, i0.rsp_valid); end
            if (k == 4) i0.waitrequest = 1'b0;
        end
        @(negedge clk); // T+5
        tests++; if (i0.chipselect !== 1'b0) begin errors++; $display("FAIL ww_cs_drop: got %b want 0", i0.chipselect); end
        tests++; if (i0.rsp_valid !== 1'b1 || i0.rsp_error !== 1'b0) begin errors++; $display("FAIL ww_rsp: got rv=%b re=%b want 1 0", i0.rsp_valid, i0.rsp_error); end
        i0.rsp_ready = 1'b1;
        @(negedge clk);
        i0.rsp_ready = 1'b0;
    endtask

    task automatic test_read_latency();
        @(negedge clk);
        rd1 = 32'h11;
        i1.cmd_valid = 1'b1; i1.cmd_write = 1'b0; i1.cmd_addr = 2'd1;
        @(negedge clk); // T+1, accepted at its end
        i1.cmd_valid = 1'b0;
        tests++; if (i1.chipselect !== 1'b1 || i1.read_n !== 1'b0) begin errors++; $display("FAIL rl_strobe: got cs=%b rn=%b want 1 0", i1.chipselect, i1.read_n); end
        @(negedge clk); // T+2
        tests++; if (i1.chipselect !== 1'b0 || i1.read_n !== 1'b1) begin errors++; $display("FAIL rl_strobe_drop: got cs=%b rn=%b want 0 1", i1.chipselect, i1.read_n); end
        tests++; if (i1.rsp_valid !== 1'b0) begin errors++; $display("FAIL rl_rsp_t2: got %b want 0", i1.rsp_valid); end
        @(negedge clk); // T+3
        rd1 = 32'h22;
        tests++; if (i1.rsp_valid !== 1'b0) begin errors++; $display("FAIL rl_rsp_t3: got %b want 0", i1.rsp_valid); end
        @(negedge clk); // T+4
        tests++; if (i1.rsp_valid !== 1'b1) begin errors++; $display("FAIL rl_rsp_valid: got %b want 1", i1.rsp_valid); end
        tests++; if (i1.rsp_rdata !== 32'h22) begin errors++; $display("FAIL rl_rdata: got %h want 22", i1.rsp_rdata); end
        i1.rsp_ready = 1'b1;
        @(negedge clk);
        i1.rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure_reset();
        int unsigned quiet;
        quiet = 0;
        @(negedge clk);
        i0.cmd_valid = 1'b1; i0.cmd_write = 1'b0; i0.cmd_addr = 2'd0;
        @(negedge clk); // T+1
        tests++; if (i0.read_n !== 1'b0) begin errors++; $display("FAIL bp_strobe: got rn=%b want 0", i0.read_n); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++; if (i0.rsp_valid !== 1'b1 || i0.rsp_rdata !== 32'hA5) begin errors++; $display("FAIL bp_hold_c%0d: got rv=%b rd=%h want 1 a5", k, i0.rsp_valid, i0.rsp_rdata); end
            tests++; if (i0.cmd_ready !== 1'b0 || i0.chipselect !== 1'b0) begin errors++; $display("FAIL bp_block_c%0d: got cr=%b cs=%b want 0 0", k, i0.cmd_ready, i0.chipselect); end
            if (k == 4) i0.rsp_ready = 1'b1;
        end
        @(negedge clk); // idle cycle after handshake; still-valid command accepted at its end
        i0.rsp_ready = 1'b0;
        tests++; if (i0.cmd_ready !== 1'b1 || i0.rsp_valid !== 1'b0 || i0.chipselect !== 1'b0) begin errors++; $display("FAIL bp_idle_gap: got cr=%b rv=%b cs=%b want 1 0 0", i0.cmd_ready, i0.rsp_valid, i0.chipselect); end
        i0.cmd_write = 1'b1; i0.cmd_wdata = 32'h0000_DEAD; i0.waitrequest = 1'b1;
        @(negedge clk);
        i0.cmd_valid = 1'b0;
        tests++; if (i0.chipselect !== 1'b1 || i0.write_n !== 1'b0) begin errors++; $display("FAIL bp_new_strobe: got cs=%b wn=%b want 1 0", i0.chipselect, i0.write_n); end
        #1 reset_n = 1'b0;
        #1;
        tests++; if (i0.chipselect !== 1'b0 || i0.write_n !== 1'b1) begin errors++; $display("FAIL rst_async: got cs=%b wn=%b want 0 1", i0.chipselect, i0.write_n); end
        #1 reset_n = 1'b1;
        i0.waitrequest = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (i0.rsp_valid === 1'b0 && i0.chipselect === 1'b0) quiet++;
        end
        tests++; if (quiet != 3) begin errors++; $display("FAIL rst_no_rsp: got %0d quiet cycles want 3", quiet); end
        tests++; if (i0.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b want 1", i0.cmd_ready); end
        tests++; if (out_port !== 32'hA5) begin errors++; $display("FAIL rst_out_port: got %h want a5", out_port); end
    endtask

    initial begin
        out_port = '0;
        rd1 = '0;
        i0.cmd_valid = 1'b0; i0.cmd_write = 1'b0; i0.cmd_addr = '0; i0.cmd_wdata = '0;
        i0.rsp_ready = 1'b0; i0.waitrequest = 1'b0;
        i1.cmd_valid = 1'b0; i1.cmd_write = 1'b0; i1.cmd_addr = '0; i1.cmd_wdata = '0;
        i1.rsp_ready = 1'b0; i1.waitrequest = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_wait_write();
        test_read_latency();
        test_backpressure_reset();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
